// File: rtl/tart_bus_master_pkg.sv
// Shared definitions for tart_bus_master: command-byte field positions,
// the byte returned on a failed read, and the FSM state encoding.
package tart_bus_master_pkg;

  localparam int         WR_BIT     = 7;
  localparam int         BURST_BIT  = 6;
  localparam logic [7:0] FAULT_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WDATA = 3'd1,
    S_LEN   = 3'd2,
    S_BUS   = 3'd3,
    S_RESP  = 3'd4,
    S_GAP   = 3'd5
  } state_e;

endpackage

// File: rtl/tart_bus_master.sv
// Byte-stream to 8-bit register bus initiator: single writes, single/burst reads.
// Optional watchdog per bus beat is enabled by defining WB_TIMEOUT_EN.
module tart_bus_master
  import tart_bus_master_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ABITS = 4,
  parameter int TOUT  = 31,
  parameter int DELAY = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_valid_i,
  input  logic [WIDTH-1:0] rx_data_i,
  output logic             rx_ready_o,
  output logic             tx_valid_o,
  output logic [WIDTH-1:0] tx_data_o,
  input  logic             tx_ready_i,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [ABITS-1:0] adr_o,
  output logic [WIDTH-1:0] dat_o,
  input  logic             ack_i,
  input  logic             wat_i,
  input  logic             rty_i,
  input  logic             err_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             busy_o,
  output logic             fault_o
);

  state_e           r_state;
  state_e           w_next;
  logic             r_we;
  logic [ABITS-1:0] r_adr;
  logic [WIDTH-1:0] r_dat;
  logic [7:0]       r_cnt;
  logic [WIDTH-1:0] r_tx_data;
  logic             r_fault;
  logic             w_timeout;
  logic             w_abort;
  logic             w_unused;

  // wat_i only means "keep waiting", which BUS already does without it.
  assign w_unused = wat_i ^ (TOUT == DELAY);

`ifdef WB_TIMEOUT_EN
  localparam logic [7:0] WDOG_LAST = 8'(TOUT - 1);
  logic [7:0] r_wdog;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wdog <= '0;
    end else if (r_state != S_BUS || rty_i) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 8'd1;
    end
  end

  assign w_timeout = (r_state == S_BUS) && (r_wdog == WDOG_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  assign w_abort = err_i | w_timeout;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    rx_ready_o = 1'b0;
    tx_valid_o = 1'b0;
    cyc_o      = 1'b0;
    stb_o      = 1'b0;
    busy_o     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        rx_ready_o = rst_ni;
        if (rx_valid_i) begin
          if (rx_data_i[WR_BIT])         w_next = S_WDATA;
          else if (rx_data_i[BURST_BIT]) w_next = S_LEN;
          else                           w_next = S_BUS;
        end
      end
      S_WDATA, S_LEN: begin
        rx_ready_o = rst_ni;
        if (rx_valid_i) w_next = S_BUS;
      end
      S_BUS: begin
        cyc_o = 1'b1;
        stb_o = 1'b1;
        // Error (or watchdog) beats a simultaneous ack.
        if (w_abort || ack_i) w_next = r_we ? S_IDLE : S_RESP;
        else if (rty_i)       w_next = S_GAP;
      end
      S_RESP: begin
        cyc_o      = 1'b1;
        tx_valid_o = 1'b1;
        if (tx_ready_i) w_next = (r_cnt == 8'd0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        cyc_o  = 1'b1;
        w_next = S_BUS;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // An aborted read clears the beat count so the 0xEE byte is the last one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_cnt     <= '0;
      r_tx_data <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_valid_i) begin
            r_we  <= rx_data_i[WR_BIT];
            r_adr <= rx_data_i[ABITS-1:0];
            r_cnt <= '0;
          end
        end
        S_WDATA: if (rx_valid_i) r_dat <= rx_data_i;
        S_LEN:   if (rx_valid_i) r_cnt <= rx_data_i;
        S_BUS: begin
          if (w_abort) begin
            r_fault <= 1'b1;
            r_cnt   <= '0;
            if (!r_we) r_tx_data <= FAULT_BYTE;
          end else if (ack_i && !r_we) begin
            r_tx_data <= dat_i;
          end
        end
        S_RESP: if (tx_ready_i && r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
        default: ;
      endcase
    end
  end

  assign we_o      = r_we;
  assign adr_o     = r_adr;
  assign dat_o     = r_dat;
  assign tx_data_o = r_tx_data;
  assign fault_o   = r_fault;

endmodule

// File: doc/tart_bus_master.md
# tart_bus_master

Byte-stream-to-bus initiator for TART's 8-bit Wishbone-like register interconnect. It takes command and data bytes from the SPI byte layer and issues classic single or burst bus cycles to the acquisition/visibilities register slaves. It returns read data as a byte stream toward the SPI transmitter. It is the master end of the interconnect those slaves respond on.

## Interface
- WIDTH, 8, bus data width (bytes only; fixed at 8)
- ABITS, 4, register-address width
- TOUT, 31, watchdog limit in cycles per bus beat (only with `WB_TIMEOUT_EN`)
- DELAY, 3, simulation-only non-blocking assignment delay
- clk_i  in  1  system clock; all logic on rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- rx_valid_i  in  1  inbound byte valid
- rx_data_i  in  8  inbound byte
- rx_ready_o  out  1  inbound byte accepted when high with rx_valid_i
- tx_valid_o  out  1  read-data byte valid
- tx_data_o  out  8  read-data byte
- tx_ready_i  in  1  downstream accepts tx byte
- cyc_o, stb_o, we_o  out  1 each  bus cycle, strobe, write-enable
- adr_o  out  ABITS  register address
- dat_o  out  8  write data
- ack_i, wat_i, rty_i, err_i  in  1 each  slave responses
- dat_i  in  8  read data, valid with ack_i
- busy_o  out  1  high in any state other than IDLE
- fault_o  out  1  one-cycle pulse on err_i or timeout

## Operation
- Command byte: bit7 = write, bit6 = burst, bits[ABITS-1:0] = address, bits[5:ABITS] ignored.
- Write: the command is followed by one data byte, which produces a single write beat. The burst bit is ignored for writes.
- Read with burst=0: one beat.
- Read with burst=1: the next byte is LEN, and the block issues LEN+1 beats (1..256) to the same address. This serves stream registers.
- FSM states and transitions:
  - IDLE: on command accept, a write goes to WDATA; a burst read goes to LEN; a single read goes to BUS.
  - WDATA: accepts the data byte, then goes to BUS.
  - LEN: accepts the count byte, then goes to BUS.
  - BUS: holds cyc_o/stb_o until ack_i.
  - RESP: holds tx_valid_o until tx_ready_i.
  - GAP: one idle cycle with stb_o=0 and cyc_o=1 between burst beats.
- rx_ready_o = 1 only in IDLE, WDATA and LEN.
- On ack_i in BUS:
  - A read latches dat_i into tx_data_o and goes to RESP.
  - A write goes to IDLE.
- On the RESP handshake: if beats remain, go to GAP and then BUS; otherwise go to IDLE.
- rty_i in BUS: drop stb_o for one cycle, then reissue the same beat.
- wat_i: treated as "keep waiting"; it has no other effect.
- err_i in BUS:
  - Pulse fault_o, abort the transaction (all remaining beats dropped), return to IDLE.
  - A read also emits a single tx byte 8'hEE before returning to IDLE.
- The beat counter is 8 bits and decrements per completed beat; the last beat is the one with count==0.

## Timing
- Reset values: rx_ready_o=0 while rst_ni is low, and 1 after release (IDLE). All other outputs are 0. adr_o, dat_o and tx_data_o are 0.
- Async reset mid-transaction: cyc_o and stb_o fall immediately. In-flight bytes are lost; no fault_o pulse.
- Command accepted at edge N gives cyc_o=stb_o=1 from edge N+1 for a single read. For a write, this happens one cycle after the data-byte edge.
- ack_i sampled high at edge M:
  - stb_o=0 from M+1.
  - For a read, tx_valid_o=1 from M+1 (tx_data_o = dat_i sampled at M).
  - cyc_o stays 1 until the final beat's ack (write) or the final RESP handshake (read), then falls.
- Minimum burst beat period is 3 cycles: BUS (ack), RESP (immediate ready), GAP. This satisfies slaves that forbid back-to-back acks.
- adr_o and we_o are stable from cycle start until cyc_o falls. dat_o is stable while stb_o=1.
- ack_i together with err_i: err_i wins.
- ack_i outside BUS: ignored.

## Configuration
- `WB_TIMEOUT_EN` defined:
  - A 5-bit+ watchdog counts cycles in BUS and clears on rty_i.
  - Reaching TOUT is handled as err_i (fault_o pulse, 8'hEE for reads, abort).
- `WB_TIMEOUT_EN` undefined: no watchdog; BUS waits indefinitely for ack_i/err_i.

## Structure
- Shared package/include (alongside tartcfg.v): command bit positions (WR_BIT=7, BURST_BIT=6), FAULT_BYTE=8'hEE, FSM state encodings.
- Single module, no sub-modules. The watchdog counter stays inline under the macro.

## Test plan
- Single write: rx 8'h87, 8'h85 → one beat with adr_o=4'h7, we_o=1, dat_o=8'h85; no tx byte; busy_o falls the cycle after ack.
- Single read: rx 8'h04, slave acks with 8'h3C after 2 wait cycles → tx byte 8'h3C; cyc_o low after the tx handshake.
- Burst read: rx 8'h48, 8'h02 → exactly 3 beats at adr 4'h8, stb_o low for ≥1 cycle between acks, tx bytes 8'h10, 8'h11, 8'h12 in order. Repeat with tx_ready_i low for 5 cycles mid-burst → no beat issued while stalled.
- Error: burst of 4, err_i on beat 2 → tx 8'h10 then 8'hEE, fault_o pulses once, no further beats.
- Timeout (`WB_TIMEOUT_EN`, TOUT=31): read, slave never acks → fault_o 31 cycles after stb_o rises, tx 8'hEE. Retry: rty_i once, then ack → beat reissued after a 1-cycle stb_o gap, single tx byte.
- Async reset asserted while in BUS → cyc_o/stb_o low without waiting for a clock edge; after release, rx_ready_o=1 and the next command executes normally.
